// File: rtl/register_rename_map_if.sv
// Rename-stage bus: decode/retire/rollback side plus the free-list port.
// slave = map table, master = decode/retire/free-list environment.
interface register_rename_map_if #(
   parameter int PHYS_ADDR_W = 6
);
   logic                   rename_valid;
   logic                   rename_ready;
   logic [4:0]             rename_rs1;
   logic [4:0]             rename_rs2;
   logic [4:0]             rename_rd;
   logic                   rename_uses_rd;
   logic [PHYS_ADDR_W-1:0] rename_phys_rs1;
   logic [PHYS_ADDR_W-1:0] rename_phys_rs2;
   logic [PHYS_ADDR_W-1:0] rename_phys_rd;
   logic [PHYS_ADDR_W-1:0] rename_prev_phys_rd;
   logic                   retire_valid;
   logic [PHYS_ADDR_W-1:0] retire_prev_phys;
   logic                   rollback;
   logic                   fl_valid;
   logic [PHYS_ADDR_W-1:0] fl_data_out;
   logic                   fl_pop;
   logic                   fl_push;
   logic                   fl_potential_push;
   logic [PHYS_ADDR_W-1:0] fl_data_in;
   logic                   fl_rollback;

   modport slave (
      input  rename_valid,
      output rename_ready,
      input  rename_rs1,
      input  rename_rs2,
      input  rename_rd,
      input  rename_uses_rd,
      output rename_phys_rs1,
      output rename_phys_rs2,
      output rename_phys_rd,
      output rename_prev_phys_rd,
      input  retire_valid,
      input  retire_prev_phys,
      input  rollback,
      input  fl_valid,
      input  fl_data_out,
      output fl_pop,
      output fl_push,
      output fl_potential_push,
      output fl_data_in,
      output fl_rollback
   );

   modport master (
      output rename_valid,
      input  rename_ready,
      output rename_rs1,
      output rename_rs2,
      output rename_rd,
      output rename_uses_rd,
      input  rename_phys_rs1,
      input  rename_phys_rs2,
      input  rename_phys_rd,
      input  rename_prev_phys_rd,
      output retire_valid,
      output retire_prev_phys,
      output rollback,
      input  fl_valid,
      input  fl_data_out,
      input  fl_pop,
      input  fl_push,
      input  fl_potential_push,
      input  fl_data_in,
      input  fl_rollback
   );
endinterface

// File: rtl/register_rename_map.sv
// Arch-to-phys rename map with free-list seeding and one-level undo.
// Optional RENAME_STALL_COUNT_EN adds a saturating free-list stall counter.
module register_rename_map #(
   parameter int PHYS_REG_COUNT = 64,
   parameter int PHYS_ADDR_W    = $clog2(PHYS_REG_COUNT)
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef RENAME_STALL_COUNT_EN
   output logic [31:0]           stall_count,
`endif
   register_rename_map_if.slave  bus
);

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_e;

   localparam logic [PHYS_ADDR_W-1:0] SEED_FIRST =
      PHYS_ADDR_W'(32);
   localparam logic [PHYS_ADDR_W-1:0] SEED_LAST =
      PHYS_ADDR_W'(PHYS_REG_COUNT - 1);

   state_e                 state_q, state_d;
   logic [PHYS_ADDR_W-1:0] init_cnt_q, init_cnt_d;
   logic [PHYS_ADDR_W-1:0] map_q [32];
   logic [PHYS_ADDR_W-1:0] map_d [32];
   logic [4:0]             undo_rd_q, undo_rd_d;
   logic [PHYS_ADDR_W-1:0] undo_prev_q, undo_prev_d;
   logic                   undo_valid_q, undo_valid_d;

   logic alloc;
   logic ready_c;
   logic fire;

   assign alloc = bus.rename_uses_rd & (bus.rename_rd != 5'd0);

   // Reads see only state from earlier cycles.
   assign bus.rename_phys_rs1 = map_q[bus.rename_rs1];
   assign bus.rename_phys_rs2 = map_q[bus.rename_rs2];

   always_comb begin
      state_d      = state_q;
      init_cnt_d   = init_cnt_q;
      map_d        = map_q;
      undo_rd_d    = undo_rd_q;
      undo_prev_d  = undo_prev_q;
      undo_valid_d = undo_valid_q;
      ready_c      = 1'b0;
      fire         = 1'b0;

      bus.rename_ready        = 1'b0;
      bus.rename_phys_rd      = '0;
      bus.rename_prev_phys_rd = '0;
      bus.fl_pop              = 1'b0;
      bus.fl_push             = 1'b0;
      bus.fl_potential_push   = 1'b0;
      bus.fl_data_in          = '0;
      bus.fl_rollback         = 1'b0;

      unique case (state_q)
         ST_INIT: begin
            // Seed every register above the identity-mapped 0..31.
            bus.fl_push           = 1'b1;
            bus.fl_potential_push = 1'b1;
            bus.fl_data_in        = init_cnt_q;
            init_cnt_d            = init_cnt_q + 1'b1;
            if (init_cnt_q == SEED_LAST) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            ready_c = ~bus.rollback & (~alloc | bus.fl_valid);
            fire    = bus.rename_valid & ready_c;

            bus.rename_ready = ready_c;
            if (alloc) begin
               bus.rename_phys_rd      = bus.fl_data_out;
               bus.rename_prev_phys_rd = map_q[bus.rename_rd];
            end

            if (fire & alloc) begin
               bus.fl_pop          = 1'b1;
               map_d[bus.rename_rd] = bus.fl_data_out;
               undo_rd_d           = bus.rename_rd;
               undo_prev_d         = map_q[bus.rename_rd];
               undo_valid_d        = 1'b1;
            end

            // Rollback and a firing rename are mutually exclusive.
            if (bus.rollback & undo_valid_q) begin
               bus.fl_rollback  = 1'b1;
               map_d[undo_rd_q] = undo_prev_q;
               undo_valid_d     = 1'b0;
            end

            bus.fl_push           = bus.retire_valid;
            bus.fl_potential_push = bus.retire_valid;
            bus.fl_data_in        = bus.retire_prev_phys;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         init_cnt_q   <= SEED_FIRST;
         undo_rd_q    <= '0;
         undo_prev_q  <= '0;
         undo_valid_q <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            map_q[i] <= PHYS_ADDR_W'(i);
         end
      end else begin
         state_q      <= state_d;
         init_cnt_q   <= init_cnt_d;
         undo_rd_q    <= undo_rd_d;
         undo_prev_q  <= undo_prev_d;
         undo_valid_q <= undo_valid_d;
         map_q        <= map_d;
      end
   end

`ifdef RENAME_STALL_COUNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        stall_hit;

   assign stall_hit = (state_q == ST_READY) & bus.rename_valid &
                      alloc & ~bus.fl_valid & ~bus.rollback;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_hit && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_register_rename_map.sv
// Bench for register_rename_map: queue free-list and map reference model,
// directed scenarios plus randomized rename/retire/rollback traffic.
module tb_register_rename_map;

   localparam int PRC = 64;
   localparam int AW  = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;

   register_rename_map_if #(.PHYS_ADDR_W(AW)) bus ();

`ifdef RENAME_STALL_COUNT_EN
   logic [31:0] stall_count;
`endif

   register_rename_map #(
      .PHYS_REG_COUNT(PRC)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef RENAME_STALL_COUNT_EN
      .stall_count(stall_count),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference state
   int     m_map [32];
   bit     m_undo_v;
   int     m_undo_rd;
   int     m_undo_prev;
   bit     m_init;
   int     m_init_cnt;
   int     flq [$];
   int     pend [$];
   int     last_pop;
   longint m_stall;

   // Expected outputs of the current cycle
   bit e_ready, e_pop, e_push, e_rb, e_stall;
   int e_prs1, e_prs2, e_prd, e_prev, e_din;
   int u_rd, u_rp;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_map[i] = i;
      m_undo_v    = 1'b0;
      m_init      = 1'b1;
      m_init_cnt  = 32;
      m_stall     = 0;
      flq.delete();
      pend.delete();
   endtask

   task automatic apply(bit v, int rs1, int rs2, int rd,
                        bit uses, bit rv, int rp, bit rb);
      bit alloc;
      bus.rename_valid     = v;
      bus.rename_rs1       = 5'(rs1);
      bus.rename_rs2       = 5'(rs2);
      bus.rename_rd        = 5'(rd);
      bus.rename_uses_rd   = uses;
      bus.retire_valid     = rv;
      bus.retire_prev_phys = AW'(rp);
      bus.rollback         = rb;
      bus.fl_valid         = flq.size() > 0;
      bus.fl_data_out      = flq.size() > 0 ? AW'(flq[0]) : '0;
      u_rd    = rd;
      u_rp    = rp;
      e_prs1  = m_map[rs1];
      e_prs2  = m_map[rs2];
      e_stall = 1'b0;
      if (m_init) begin
         e_ready = 0; e_pop = 0; e_rb = 0;
         e_push  = 1; e_din = m_init_cnt;
         e_prd   = 0; e_prev = 0;
      end else begin
         alloc   = uses && rd != 0;
         e_ready = !rb && (!alloc || flq.size() > 0);
         e_pop   = v && e_ready && alloc;
         e_prd   = !alloc ? 0 : (flq.size() > 0 ? flq[0] : 0);
         e_prev  = alloc ? m_map[rd] : 0;
         e_push  = rv;
         e_din   = rp;
         e_rb    = rb && m_undo_v;
         e_stall = v && alloc && flq.size() == 0 && !rb;
      end
      #3;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      if (m_init) begin
         flq.push_back(m_init_cnt);
         m_init_cnt++;
         if (m_init_cnt == PRC) m_init = 1'b0;
      end else begin
         if (e_pop) begin
            last_pop    = flq.pop_front();
            pend.push_back(e_prev);
            m_undo_v    = 1'b1;
            m_undo_rd   = u_rd;
            m_undo_prev = m_map[u_rd];
            m_map[u_rd] = e_prd;
         end
         if (e_rb) begin
            m_map[m_undo_rd] = m_undo_prev;
            flq.push_front(last_pop);
            m_undo_v = 1'b0;
            if (pend.size() > 0) void'(pend.pop_back());
         end
         if (e_push) flq.push_back(u_rp);
         if (e_stall && m_stall != 64'hffff_ffff) m_stall++;
      end
   endtask

   task automatic idle();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      advance();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_init();
      for (int k = 0; k < PRC - 32; k++) idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      model_reset();
      n_vec++;
      if (bus.rename_ready !== 1'b0 || bus.fl_pop !== 1'b0 ||
          bus.fl_rollback !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ctrl: ready=%b pop=%b rb=%b want 0 0 0",
                  bus.rename_ready, bus.fl_pop, bus.fl_rollback);
      end
      n_vec++;
      if (bus.fl_push !== 1'b1 || bus.fl_data_in !== AW'(32)) begin
         n_fail++;
         $display("FAIL rst_push: push=%b din=%0d want 1 32",
                  bus.fl_push, bus.fl_data_in);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      // Retire and rollback must be ignored while seeding
      for (int k = 0; k < PRC - 32; k++) begin
         apply(0, 0, 0, 0, 0, 1, $urandom_range(0, PRC - 1), 1);
         n_vec++;
         if (bus.fl_push !== 1'b1 || bus.fl_data_in !== AW'(32 + k) ||
             bus.fl_potential_push !== 1'b1) begin
            n_fail++;
            $display("FAIL init_seed[%0d]: push=%b din=%0d want 1 %0d",
                     k, bus.fl_push, bus.fl_data_in, 32 + k);
         end
         n_vec++;
         if (bus.rename_ready !== 1'b0 || bus.fl_rollback !== 1'b0) begin
            n_fail++;
            $display("FAIL init_ctrl[%0d]: ready=%b rb=%b want 0 0",
                     k, bus.rename_ready, bus.fl_rollback);
         end
         advance();
      end
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (bus.rename_ready !== 1'b1 || bus.fl_push !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_rise: ready=%b push=%b want 1 0",
                  bus.rename_ready, bus.fl_push);
      end
      advance();
      apply(0, 0, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (bus.fl_rollback !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_undo: fl_rollback=%b want 0", bus.fl_rollback);
      end
      advance();
   endtask

   task automatic test_rename();
      apply(1, 5, 0, 5, 1, 0, 0, 0);
      n_vec++;
      if (bus.rename_phys_rs1 !== AW'(5) ||
          bus.rename_phys_rd !== AW'(32) ||
          bus.rename_prev_phys_rd !== AW'(5) || bus.fl_pop !== 1'b1) begin
         n_fail++;
         $display("FAIL rename_rd5: rs1=%0d rd=%0d prev=%0d pop=%b want 5 32 5 1",
                  bus.rename_phys_rs1, bus.rename_phys_rd,
                  bus.rename_prev_phys_rd, bus.fl_pop);
      end
      advance();
      apply(1, 5, 5, 0, 0, 0, 0, 0);
      n_vec++;
      if (bus.rename_phys_rs1 !== AW'(32) ||
          bus.rename_phys_rs2 !== AW'(32) ||
          bus.rename_phys_rd !== '0 || bus.rename_prev_phys_rd !== '0 ||
          bus.fl_pop !== 1'b0) begin
         n_fail++;
         $display("FAIL rename_read: rs1=%0d rs2=%0d rd=%0d prev=%0d pop=%b want 32 32 0 0 0",
                  bus.rename_phys_rs1, bus.rename_phys_rs2,
                  bus.rename_phys_rd, bus.rename_prev_phys_rd, bus.fl_pop);
      end
      advance();
   endtask

   task automatic test_rollback();
      apply(1, 5, 0, 6, 1, 0, 0, 1);
      n_vec++;
      if (bus.fl_rollback !== 1'b1 || bus.rename_ready !== 1'b0 ||
          bus.fl_pop !== 1'b0) begin
         n_fail++;
         $display("FAIL rollback1: rb=%b ready=%b pop=%b want 1 0 0",
                  bus.fl_rollback, bus.rename_ready, bus.fl_pop);
      end
      advance();
      apply(0, 5, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (bus.rename_phys_rs1 !== AW'(5) || bus.fl_rollback !== 1'b0) begin
         n_fail++;
         $display("FAIL rollback2: rs1=%0d rb=%b want 5 0",
                  bus.rename_phys_rs1, bus.fl_rollback);
      end
      advance();
      apply(1, 0, 0, 10, 1, 0, 0, 0);
      n_vec++;
      if (bus.rename_phys_rd !== AW'(32) || bus.fl_pop !== 1'b1) begin
         n_fail++;
         $display("FAIL unpop_head: rd=%0d pop=%b want 32 1",
                  bus.rename_phys_rd, bus.fl_pop);
      end
      advance();
   endtask

   task automatic test_exhaust();
      pulse_reset();
      run_init();
      for (int i = 0; i < 32; i++) begin
         apply(1, 0, 0, 1 + (i % 31), 1, 0, 0, 0);
         n_vec++;
         if (bus.fl_pop !== 1'b1 || bus.rename_phys_rd !== AW'(32 + i)) begin
            n_fail++;
            $display("FAIL drain[%0d]: pop=%b rd=%0d want 1 %0d",
                     i, bus.fl_pop, bus.rename_phys_rd, 32 + i);
         end
         advance();
      end
      apply(1, 0, 0, 4, 1, 0, 0, 0);
      n_vec++;
      if (bus.rename_ready !== 1'b0 || bus.fl_pop !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_stall: ready=%b pop=%b want 0 0",
                  bus.rename_ready, bus.fl_pop);
      end
      advance();
      apply(1, 0, 0, 0, 1, 1, 7, 0);
      n_vec++;
      if (bus.rename_ready !== 1'b1 || bus.fl_pop !== 1'b0 ||
          bus.fl_push !== 1'b1 || bus.fl_data_in !== AW'(7)) begin
         n_fail++;
         $display("FAIL rd0_retire: ready=%b pop=%b push=%b din=%0d want 1 0 1 7",
                  bus.rename_ready, bus.fl_pop, bus.fl_push, bus.fl_data_in);
      end
      advance();
      apply(1, 0, 0, 9, 1, 1, 3, 0);
      n_vec++;
      if (bus.fl_push !== 1'b1 || bus.fl_pop !== 1'b1 ||
          bus.fl_data_in !== AW'(3) || bus.rename_phys_rd !== AW'(7) ||
          bus.rename_prev_phys_rd !== AW'(40)) begin
         n_fail++;
         $display("FAIL push_pop: push=%b pop=%b din=%0d rd=%0d prev=%0d want 1 1 3 7 40",
                  bus.fl_push, bus.fl_pop, bus.fl_data_in,
                  bus.rename_phys_rd, bus.rename_prev_phys_rd);
      end
      advance();
      apply(1, 9, 0, 12, 1, 0, 0, 0);
      n_vec++;
      if (bus.rename_phys_rs1 !== AW'(7) || bus.rename_phys_rd !== AW'(3) ||
          bus.fl_pop !== 1'b1) begin
         n_fail++;
         $display("FAIL after_pp: rs1=%0d rd=%0d pop=%b want 7 3 1",
                  bus.rename_phys_rs1, bus.rename_phys_rd, bus.fl_pop);
      end
      advance();
      apply(1, 0, 0, 13, 1, 0, 0, 0);
      n_vec++;
      if (bus.rename_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reempty: ready=%b want 0", bus.rename_ready);
      end
      advance();
   endtask

   task automatic test_reset_mid();
      apply(1, 0, 0, 17, 1, 1, 2, 0);
      advance();
      rst = 1'b1;
      apply(1, 17, 0, 17, 1, 1, 2, 1);
      @(posedge clk);
      #1;
      model_reset();
      n_vec++;
      if (bus.fl_push !== 1'b1 || bus.fl_data_in !== AW'(32) ||
          bus.rename_ready !== 1'b0 || bus.rename_phys_rs1 !== AW'(17)) begin
         n_fail++;
         $display("FAIL mid_reset: push=%b din=%0d ready=%b rs1=%0d want 1 32 0 17",
                  bus.fl_push, bus.fl_data_in, bus.rename_ready,
                  bus.rename_phys_rs1);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_init();
      apply(0, 17, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (bus.rename_phys_rs1 !== AW'(17) || bus.fl_rollback !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_undo: rs1=%0d rb=%b want 17 0",
                  bus.rename_phys_rs1, bus.fl_rollback);
      end
      advance();
   endtask

`ifdef RENAME_STALL_COUNT_EN
   task automatic test_stall_count();
      pulse_reset();
      run_init();
      for (int i = 0; i < 32; i++) begin
         apply(1, 0, 0, 1 + (i % 31), 1, 0, 0, 0);
         advance();
      end
      for (int i = 0; i < 5; i++) begin
         apply(1, 0, 0, 3, 1, 0, 0, 0);
         advance();
      end
      apply(1, 0, 0, 3, 1, 0, 0, 1);
      n_vec++;
      if (stall_count !== 32'd5 || m_stall != 5) begin
         n_fail++;
         $display("FAIL stall_5: got %0d want 5", stall_count);
      end
      advance();
      rst = 1'b1;
      apply(1, 0, 0, 3, 1, 0, 0, 0);
      @(posedge clk);
      #1;
      model_reset();
      n_vec++;
      if (stall_count !== 32'd0 || bus.fl_data_in !== AW'(32)) begin
         n_fail++;
         $display("FAIL stall_rst: cnt=%0d din=%0d want 0 32",
                  stall_count, bus.fl_data_in);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_init();
   endtask
`endif

   task automatic test_random();
      int v, rs1, rs2, rd, uses, rv, rp, rb, p;
      pulse_reset();
      run_init();
      for (int c = 0; c < 900; c++) begin
         p    = ((c / 150) % 2) != 0 ? 60 : 5;
         v    = ($urandom % 4) != 0;
         rs1  = $urandom % 32;
         rs2  = $urandom % 32;
         rd   = $urandom % 32;
         uses = ($urandom % 8) != 0;
         rb   = ($urandom % 10) == 0;
         rv   = pend.size() > int'(m_undo_v) && ($urandom % 100) < p;
         rp   = rv ? pend.pop_front() : $urandom % PRC;
         apply(v[0], rs1, rs2, rd, uses[0], rv[0], rp, rb[0]);
         n_vec++;
         if (bus.rename_ready !== e_ready || bus.fl_pop !== e_pop ||
             bus.fl_push !== e_push || bus.fl_rollback !== e_rb) begin
            n_fail++;
            $display("FAIL rnd_ctrl[%0d]: rdy/pop/push/rb=%b%b%b%b want %b%b%b%b",
                     c, bus.rename_ready, bus.fl_pop, bus.fl_push,
                     bus.fl_rollback, e_ready, e_pop, e_push, e_rb);
         end
         n_vec++;
         if (bus.rename_phys_rs1 !== AW'(e_prs1) ||
             bus.rename_phys_rs2 !== AW'(e_prs2)) begin
            n_fail++;
            $display("FAIL rnd_src[%0d]: rs1=%0d rs2=%0d want %0d %0d",
                     c, bus.rename_phys_rs1, bus.rename_phys_rs2,
                     e_prs1, e_prs2);
         end
         n_vec++;
         if (bus.rename_phys_rd !== AW'(e_prd) ||
             bus.rename_prev_phys_rd !== AW'(e_prev)) begin
            n_fail++;
            $display("FAIL rnd_dst[%0d]: rd=%0d prev=%0d want %0d %0d",
                     c, bus.rename_phys_rd, bus.rename_prev_phys_rd,
                     e_prd, e_prev);
         end
         if (e_push) begin
            n_vec++;
            if (bus.fl_data_in !== AW'(e_din)) begin
               n_fail++;
               $display("FAIL rnd_din[%0d]: got %0d want %0d",
                        c, bus.fl_data_in, e_din);
            end
         end
`ifdef RENAME_STALL_COUNT_EN
         n_vec++;
         if (stall_count !== 32'(m_stall)) begin
            n_fail++;
            $display("FAIL rnd_stall[%0d]: got %0d want %0d",
                     c, stall_count, m_stall);
         end
`endif
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_rename();
      test_rollback();
      test_exhaust();
      test_reset_mid();
`ifdef RENAME_STALL_COUNT_EN
      test_stall_count();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/register_rename_map.md
Name: register_rename_map

Overview:
Rename-stage map table sitting directly upstream of the physical register free list. It owns the architectural-to-physical mapping for x0..x31. On each rename it pops a new physical register from the free list, and on retire it pushes the superseded physical register back. It seeds the free list after reset and can undo the most recent rename, driving the free list's rollback input.

Parameters:
- PHYS_REG_COUNT, 64, total physical registers; power of 2, greater than 32.
- PHYS_ADDR_W, $clog2(PHYS_REG_COUNT), width of a physical register id.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rename_valid  in  1  decode presents an instruction.
- rename_ready  out  1  rename can fire this cycle.
- rename_rs1  in  5  arch source 1.
- rename_rs2  in  5  arch source 2.
- rename_rd  in  5  arch destination.
- rename_uses_rd  in  1  instruction writes rd.
- rename_phys_rs1  out  PHYS_ADDR_W  mapped rs1.
- rename_phys_rs2  out  PHYS_ADDR_W  mapped rs2.
- rename_phys_rd  out  PHYS_ADDR_W  newly allocated phys rd (fl_data_out).
- rename_prev_phys_rd  out  PHYS_ADDR_W  previous mapping of rd.
- retire_valid  in  1  retiring instruction frees retire_prev_phys.
- retire_prev_phys  in  PHYS_ADDR_W  phys reg to release.
- rollback  in  1  undo most recent allocating rename.
- fl_valid  in  1  free list non-empty.
- fl_data_out  in  PHYS_ADDR_W  free list head.
- fl_pop  out  1  pop free list.
- fl_push  out  1  push to free list.
- fl_potential_push  out  1  write-enable for free list storage.
- fl_data_in  out  PHYS_ADDR_W  value pushed.
- fl_rollback  out  1  un-pop the last popped entry.

Behaviour:
- Map table: 32 entries of PHYS_ADDR_W flops. Reset loads map[i] = i. Reads are combinational and reflect writes from prior cycles only, so rs1 == rd in the same instruction returns the old mapping.
- FSM states are INIT and READY. Reset enters INIT with init_count = 32.
- INIT: fl_push = fl_potential_push = 1 and fl_data_in = init_count each cycle; init_count increments. After pushing PHYS_REG_COUNT-1 the FSM moves to READY. INIT lasts exactly PHYS_REG_COUNT-32 cycles. rename_ready = 0 in INIT; retire_valid and rollback are ignored.
- READY: a rename allocates when alloc = rename_uses_rd & (rename_rd != 0). rename_ready = ~rollback & (~alloc | fl_valid). A rename fires on rename_valid & rename_ready.
- Fire with alloc: fl_pop = 1; map[rd] <= fl_data_out; undo register <= {rd, prev map[rd]}; undo_valid <= 1.
- Fire without alloc: no pop. rename_phys_rd = 0 and rename_prev_phys_rd = 0. undo_valid is unchanged.
- Retire (READY): fl_push = fl_potential_push = retire_valid; fl_data_in = retire_prev_phys. Retire is independent of rename and rollback and may coincide with either.
- Rollback (READY):
  - If undo_valid: map[undo_rd] <= undo_prev; fl_rollback = 1; undo_valid <= 0.
  - If undo_valid = 0: no effect, fl_rollback = 0.
  - Rollback blocks rename in the same cycle.
  - Only one level of undo is kept; a second rollback without an intervening allocating rename is a no-op.
- Free list empty: allocating renames stall. Non-allocating renames (rd = 0 or no rd) still fire.
- Reset mid-operation: the map returns to identity, undo_valid = 0, and the FSM reseeds. The free list is reset by the same rst.
- Reset values: rename_ready = 0; fl_pop = fl_rollback = 0; fl_push = 1 (INIT is entered immediately); fl_data_in = 32; undo_valid = 0.

Optional Feature:
- Macro: RENAME_STALL_COUNT_EN.
- When defined: adds output stall_count (32 bits, reset 0). It increments each READY cycle with rename_valid & alloc & ~fl_valid & ~rollback, and saturates at all-ones.
- When not defined: the port and counter do not exist. No other behaviour changes.

Test Plan:
- Reset, then hold rename_valid = 0 -> fl_push high for 32 cycles with fl_data_in = 32..63; rename_ready rises on cycle 33.
- rename rd = 5, rs1 = 5, uses_rd, fl_data_out = 32 -> phys_rs1 = 5, phys_rd = 32, prev_phys_rd = 5, fl_pop = 1. Next rename with rs1 = 5 -> phys_rs1 = 32.
- After rd = 5 -> 32, assert rollback -> fl_rollback = 1, rename_ready = 0 that cycle; next rs1 = 5 -> 5. A second rollback -> fl_rollback = 0.
- Perform 32 allocating renames with no retire -> the 33rd allocating rename sees rename_ready = 0. A rename with rd = 0 in that state fires with fl_pop = 0. Retire of prev 7 in the same cycle -> fl_push = 1, fl_data_in = 7.
- In the same cycle, retire of prev 3 plus an allocating rename -> fl_push = 1 and fl_pop = 1, map updated, and the free list remains consistent.
- With RENAME_STALL_COUNT_EN: 5 cycles of allocating rename_valid with the free list empty -> stall_count = 5. Reset mid-stall -> stall_count = 0 and INIT restarts at 32.
